// File: rtl/multi_block_write_ctrl.sv
// ============================================================================
// Module   : multi_block_write_ctrl
// Purpose  : Sequences multi-block SD data writes, feeding buffer words to the
//            data-write engine and tracking block count, stop and errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_block_write_ctrl #(
  parameter int MaxBlockBitSize = 12,
  parameter int BlockCountWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_p_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic                       multi_block_i,
  input  logic [31:0]                buf_data_i,
  input  logic                       buf_valid_i,
  output logic                       buf_pop_o,
  output logic                       wr_start_o,
  output logic [31:0]                wr_data_o,
  input  logic                       wr_next_word_i,
  input  logic                       wr_done_i,
  input  logic                       wr_crc_err_i,
  input  logic                       wr_end_bit_err_i,
  output logic                       busy_o,
  output logic                       block_done_o,
  output logic                       xfer_done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       underrun_err_o,
  output logic [BlockCountWidth-1:0] blocks_left_o
);

  localparam int WCNT_W = MaxBlockBitSize - 2;
  localparam logic [WCNT_W-1:0]          WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [BlockCountWidth-1:0] BLK_ONE  = {{(BlockCountWidth-1){1'b0}}, 1'b1};
  localparam logic [BlockCountWidth-1:0] BLK_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFETCH  = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [WCNT_W-1:0]           words_per_block;
  logic [WCNT_W-1:0]           word_cnt;
  logic [WCNT_W-1:0]           last_idx;
  logic                        stop_pending;
  logic                        in_block;
  logic                        start_acc;
  logic                        prefetch_pop;
  logic                        word_req;
  logic                        word_pop;
  logic                        word_miss;
  logic                        done_acc;
  logic                        blk_err;
  logic                        cont;
  logic [BlockCountWidth-1:0]  blocks_left_dec;
  logic                        unused_size_lsbs;

  // Sizes are whole words, so the two byte-offset bits carry no information.
  assign unused_size_lsbs = ^block_size_i[1:0];

  assign last_idx     = words_per_block - WCNT_ONE;
  assign in_block     = (state == SEND) || (state == WAIT_DONE);
  assign start_acc    = (state == IDLE) && start_i;
  assign prefetch_pop = (state == PREFETCH) && buf_valid_i;
  // The engine's trailing request after the last word is not a real fetch.
  assign word_req     = in_block && wr_next_word_i && (word_cnt != last_idx);
  assign word_pop     = word_req && buf_valid_i;
  assign word_miss    = word_req && !buf_valid_i;
  assign done_acc     = in_block && wr_done_i;
  assign blk_err      = wr_crc_err_i || wr_end_bit_err_i;

  assign blocks_left_dec = (blocks_left_o != BLK_ZERO) ? (blocks_left_o - BLK_ONE) : BLK_ZERO;

  assign cont = !blk_err && !underrun_err_o && !word_miss &&
                (blocks_left_dec != BLK_ZERO) && !stop_pending && !stop_i;

  assign buf_pop_o   = prefetch_pop || word_pop;
  assign wr_start_o  = (state == START);
  assign busy_o      = (state != IDLE);
  assign xfer_done_o = (state == FINISH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = PREFETCH;
      end
      PREFETCH: begin
        if (buf_valid_i) state_nxt = START;
      end
      START: begin
        if (sd_clk_en_p_i) state_nxt = SEND;
      end
      SEND: begin
        if (done_acc) begin
          state_nxt = cont ? PREFETCH : FINISH;
        end else if (word_cnt == last_idx) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_acc) state_nxt = cont ? PREFETCH : FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_per_block <= '0;
      word_cnt        <= '0;
      stop_pending    <= 1'b0;
      wr_data_o       <= '0;
      blocks_left_o   <= '0;
      block_done_o    <= 1'b0;
      crc_err_o       <= 1'b0;
      end_bit_err_o   <= 1'b0;
      underrun_err_o  <= 1'b0;
    end else begin
      block_done_o <= 1'b0;

      if (start_acc) begin
        words_per_block <= block_size_i[MaxBlockBitSize-1:2];
        word_cnt        <= '0;
        stop_pending    <= 1'b0;
        crc_err_o       <= 1'b0;
        end_bit_err_o   <= 1'b0;
        underrun_err_o  <= 1'b0;
        if (multi_block_i && (block_count_i != BLK_ZERO)) begin
          blocks_left_o <= block_count_i;
        end else begin
          blocks_left_o <= BLK_ONE;
        end
      end

      if ((state != IDLE) && stop_i) begin
        stop_pending <= 1'b1;
      end

      if (prefetch_pop) begin
        wr_data_o <= buf_data_i;
        word_cnt  <= '0;
      end

      if (word_req) begin
        word_cnt <= word_cnt + WCNT_ONE;
        if (buf_valid_i) begin
          wr_data_o <= buf_data_i;
        end else begin
          underrun_err_o <= 1'b1;
        end
      end

      if (done_acc) begin
        crc_err_o     <= crc_err_o || wr_crc_err_i;
        end_bit_err_o <= end_bit_err_o || wr_end_bit_err_i;
        blocks_left_o <= blocks_left_dec;
        block_done_o  <= !blk_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_block_write_ctrl.sv
// ============================================================================
// Module   : tb_multi_block_write_ctrl
// Purpose  : Directed bench for multi_block_write_ctrl with a buffer FIFO and
//            a simple data-write engine model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_block_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] block_size = 12'd0;
  logic [15:0] block_count = 16'd0;
  logic        multi = 1'b0;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic        buf_pop;
  logic        wr_start;
  logic [31:0] wr_data;
  logic        next_word = 1'b0;
  logic        done = 1'b0;
  logic        crc_in = 1'b0;
  logic        eb_in = 1'b0;
  logic        busy;
  logic        block_done;
  logic        xfer_done;
  logic        crc_err;
  logic        eb_err;
  logic        ur_err;
  logic [15:0] blocks_left;

  int rd_ptr = 0;
  int avail  = 0;
  int pop_cnt = 0, start_cnt = 0, bd_cnt = 0, xd_cnt = 0;
  logic prev_start = 1'b0;
  int n_checks = 0, n_err = 0;

  multi_block_write_ctrl #(.MaxBlockBitSize(12), .BlockCountWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sd_clk_en_p_i(sd_en),
    .start_i(start), .stop_i(stop), .block_size_i(block_size),
    .block_count_i(block_count), .multi_block_i(multi),
    .buf_data_i(buf_data), .buf_valid_i(buf_valid), .buf_pop_o(buf_pop),
    .wr_start_o(wr_start), .wr_data_o(wr_data), .wr_next_word_i(next_word),
    .wr_done_i(done), .wr_crc_err_i(crc_in), .wr_end_bit_err_i(eb_in),
    .busy_o(busy), .block_done_o(block_done), .xfer_done_o(xfer_done),
    .crc_err_o(crc_err), .end_bit_err_o(eb_err), .underrun_err_o(ur_err),
    .blocks_left_o(blocks_left)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sd_en <= ~sd_en;

  function automatic logic [31:0] word_of(input int i);
    logic [31:0] w;
    w = i;
    return {16'hC0DE, w[15:0]};
  endfunction

  assign buf_data  = word_of(rd_ptr);
  assign buf_valid = (rd_ptr < avail);

  // Buffer FIFO and event counters, sampled on the active edge.
  always @(posedge clk) begin
    if (buf_pop) rd_ptr <= rd_ptr + 1;
    if (buf_pop) pop_cnt <= pop_cnt + 1;
    if (wr_start && !prev_start) start_cnt <= start_cnt + 1;
    prev_start <= wr_start;
    if (block_done) bd_cnt <= bd_cnt + 1;
    if (xfer_done) xd_cnt <= xd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int size, input int cnt, input bit m);
    tick();
    block_size  = size[11:0];
    block_count = cnt[15:0];
    multi       = m;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Engine model: accept start, request wpb words, then report completion.
  task automatic run_block(input int wpb, input int base, input bit crc, input bit eb,
                           input bit chk, input int stop_sel);
    int n = 0;
    int bad = 0;
    @(negedge clk);
    while (!(wr_start && sd_en) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      check("wr_start_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < wpb; k++) begin
      repeat (4) tick();
      @(negedge clk);
      if (chk && (wr_data !== word_of(base + k))) bad++;
      tick();
      next_word = 1'b1;
      stop = (stop_sel == k);
      tick();
      next_word = 1'b0;
      stop = 1'b0;
    end
    if (chk) check("data_words_bad", bad, 0);
    repeat (3) tick();
    done   = 1'b1;
    crc_in = crc;
    eb_in  = eb;
    stop   = (stop_sel == wpb);
    tick();
    done   = 1'b0;
    crc_in = 1'b0;
    eb_in  = 1'b0;
    stop   = 1'b0;
  endtask

  task automatic wait_xfer(input int base);
    int n = 0;
    while (xd_cnt == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("xfer_done_cnt", xd_cnt - base, 1);
  endtask

  int b, p0, s0, d0, x0;

  task automatic snap();
    p0 = pop_cnt;
    s0 = start_cnt;
    d0 = bd_cnt;
    x0 = xd_cnt;
    b  = rd_ptr;
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_outs", {wr_start, buf_pop, block_done, xfer_done, crc_err, eb_err, ur_err}, 0);
    check("rst_data", wr_data, 0);
    check("rst_left", blocks_left, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single block of 512 bytes; multi=0 forces one block.
    snap();
    avail = b + 128;
    start_xfer(512, 5, 1'b0);
    @(negedge clk);
    check("single_left_init", blocks_left, 1);
    check("single_busy", busy, 1);
    run_block(128, b, 1'b0, 1'b0, 1'b1, -1);
    wait_xfer(x0);
    check("single_pops", pop_cnt - p0, 128);
    check("single_bd", bd_cnt - d0, 1);
    check("single_left", blocks_left, 0);
    check("single_errs", {crc_err, eb_err, ur_err}, 0);
    check("single_idle", busy, 0);

    // Three blocks; a start pulse mid-transfer must be ignored.
    snap();
    avail = b + 384;
    start_xfer(512, 3, 1'b1);
    block_count = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) run_block(128, b + 128 * i, 1'b0, 1'b0, 1'b1, -1);
    wait_xfer(x0);
    check("multi_bd", bd_cnt - d0, 3);
    check("multi_pops", pop_cnt - p0, 384);
    check("multi_starts", start_cnt - s0, 3);
    check("multi_left", blocks_left, 0);

    // CRC error on block 2 of 4.
    snap();
    avail = b + 64;
    start_xfer(64, 4, 1'b1);
    run_block(16, b, 1'b0, 1'b0, 1'b1, -1);
    run_block(16, b + 16, 1'b1, 1'b0, 1'b1, -1);
    wait_xfer(x0);
    check("crc_flag", {crc_err, eb_err, ur_err}, 3'b100);
    check("crc_bd", bd_cnt - d0, 1);
    check("crc_left", blocks_left, 2);
    check("crc_starts", start_cnt - s0, 2);

    // Stop during block 1 of 5; error flags cleared by the new start.
    snap();
    avail = b + 64;
    start_xfer(64, 5, 1'b1);
    @(negedge clk);
    check("start_clears_crc", crc_err, 0);
    run_block(16, b, 1'b0, 1'b0, 1'b1, 5);
    wait_xfer(x0);
    check("stop_bd", bd_cnt - d0, 1);
    check("stop_left", blocks_left, 4);
    check("stop_starts", start_cnt - s0, 1);

    // Stop coinciding with completion of block 2 of 3.
    snap();
    avail = b + 64;
    start_xfer(16, 3, 1'b1);
    run_block(4, b, 1'b0, 1'b0, 1'b1, -1);
    run_block(4, b + 4, 1'b0, 1'b0, 1'b1, 4);
    wait_xfer(x0);
    check("stopdone_bd", bd_cnt - d0, 2);
    check("stopdone_left", blocks_left, 1);

    // End-bit error on a single block.
    snap();
    avail = b + 64;
    start_xfer(16, 1, 1'b1);
    run_block(4, b, 1'b0, 1'b1, 1'b1, -1);
    wait_xfer(x0);
    check("eb_flag", {crc_err, eb_err, ur_err}, 3'b010);
    check("eb_bd", bd_cnt - d0, 0);

    // Underrun: only nine words available for a 16-word block.
    snap();
    avail = b + 9;
    start_xfer(64, 2, 1'b1);
    run_block(16, b, 1'b0, 1'b0, 1'b0, -1);
    wait_xfer(x0);
    check("ur_flag", ur_err, 1);
    check("ur_data_held", wr_data, word_of(b + 8));
    check("ur_pops", pop_cnt - p0, 9);
    check("ur_starts", start_cnt - s0, 1);
    check("ur_left", blocks_left, 1);

    // One-word blocks, count 0 treated as 1.
    snap();
    avail = b + 8;
    start_xfer(4, 0, 1'b1);
    @(negedge clk);
    check("w1_left_init", blocks_left, 1);
    run_block(1, b, 1'b0, 1'b0, 1'b1, -1);
    wait_xfer(x0);
    check("w1_pops", pop_cnt - p0, 1);
    check("w1_bd", bd_cnt - d0, 1);
    check("w1_left", blocks_left, 0);

    // Reset in the middle of SEND.
    snap();
    avail = b + 64;
    start_xfer(64, 2, 1'b1);
    repeat (8) tick();
    tick();
    next_word = 1'b1;
    tick();
    next_word = 1'b0;
    tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outs", {wr_start, buf_pop, block_done, xfer_done, crc_err, eb_err, ur_err}, 0);
    check("midrst_data", wr_data, 0);
    check("midrst_left", blocks_left, 0);
    repeat (5) @(negedge clk);
    check("midrst_no_xfer", xd_cnt - x0, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
